// File: rtl/layer_output_collector.sv
// layer_output_collector: captures one frame of layer output pixels, then
// replays it over a valid/ready stream.
// The replay path is two registered stages: a synchronous memory read, then
// the output beat. This allows back-to-back beats while out_ready stays high.
module layer_output_collector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 196,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_done,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [ADDR_W:0]          count,
    output logic                     overflow,
    output logic                     short_frame
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   rd_ptr;   // next word to fetch from the buffer
    logic [DATA_W-1:0] rd_data;  // read stage: registered memory output
    logic              rd_vld;
    logic              rd_last;

    logic              full;
    logic              cap_we;
    logic [ADDR_W:0]   count_fin;
    logic              restart;
    logic              adv;
    logic              issue;
    logic              accept_last;

    // A beat is written only in CAPTURE. An arm in the same cycle takes
    // priority and discards the beat.
    assign full      = (count == DEPTH_C);
    assign restart   = arm && (state != S_DRAIN);
    assign cap_we    = (state == S_CAPTURE) && in_valid && !arm && !full;
    // count_fin includes a beat that arrives in the same cycle as in_done.
    assign count_fin = count + (ADDR_W+1)'(cap_we);

    // The pipeline shifts whenever the output slot is empty or is being consumed.
    assign adv         = !out_valid || out_ready;
    assign issue       = (state == S_DRAIN) && adv && (rd_ptr < count);
    assign accept_last = out_valid && out_ready && out_last;

    assign busy = (state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!arm && in_done)
                    state_nxt = (count_fin == '0) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (accept_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame bookkeeping: word count, sticky integrity flags, drain read pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            count       <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            rd_ptr      <= '0;
        end else if (restart) begin
            count       <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            rd_ptr      <= '0;
        end else begin
            if (state == S_CAPTURE) begin
                if (in_valid && full) overflow <= 1'b1;
                count <= count_fin;
                if (in_done) begin
                    if (count_fin < DEPTH_C) short_frame <= 1'b1;
                    rd_ptr <= '0;
                end
            end else if (state == S_DRAIN) begin
                if (in_valid) overflow <= 1'b1;
                if (issue)    rd_ptr   <= rd_ptr + ONE_C;
            end
        end
    end

    // Frame buffer: write port for capture, synchronous read port for drain
    always_ff @(posedge clk) begin
        if (cap_we) mem[count[ADDR_W-1:0]] <= in_data;
        if (issue)  rd_data <= mem[rd_ptr[ADDR_W-1:0]];
    end

    // Two-stage drain pipeline (read stage, then output beat); the whole pipeline holds while the output is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            rd_vld    <= issue;
            rd_last   <= issue && (rd_ptr == count - ONE_C);
            out_valid <= rd_vld;
            out_data  <= rd_data;
            out_last  <= rd_last;
        end
    end

endmodule

// File: tb/tb_layer_output_collector.sv
// tb_layer_output_collector: directed frames against a queue-based model of the
// collector, plus hand-computed literal expectations.
module tb_layer_output_collector;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 196;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              arm = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_done = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid, out_last, busy, overflow, short_frame;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   count;
    logic              out_ready = 1'b1;
    logic              bp_mode = 1'b0;
    logic              chk_en = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    layer_output_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_data(in_data),
        .in_done(in_done), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .count(count),
        .overflow(overflow), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    // out_ready is high unless backpressure mode toggles it every cycle.
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ~out_ready : 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: the captured frame is a queue. The drain walks through it one
    // accepted handshake at a time.
    logic [DATA_W-1:0] cap[$];
    logic [DATA_W-1:0] rx[$];
    int   m_mode = 0;  // 0 idle, 1 capture, 2 drain
    int   d_idx  = 0;
    logic m_ovf = 1'b0, m_short = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = 0; cap.delete(); d_idx = 0; m_ovf = 1'b0; m_short = 1'b0;
        end else if (m_mode == 0) begin
            if (arm) begin cap.delete(); m_ovf = 1'b0; m_short = 1'b0; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (arm) begin
                cap.delete(); m_ovf = 1'b0; m_short = 1'b0;
            end else begin
                if (in_valid) begin
                    if (cap.size() < DEPTH) cap.push_back(in_data);
                    else m_ovf = 1'b1;
                end
                if (in_done) begin
                    if (cap.size() < DEPTH) m_short = 1'b1;
                    if (cap.size() == 0) m_mode = 0;
                    else begin m_mode = 2; d_idx = 0; end
                end
            end
        end else begin
            if (in_valid) m_ovf = 1'b1;
            if (out_valid && out_ready) begin
                rx.push_back(out_data);
                d_idx++;
                if (d_idx == cap.size()) m_mode = 0;
            end
        end
    end

    // Compare the DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("count", 32'(count), 32'(cap.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("short_frame", 32'(short_frame), 32'(m_short));
            if (m_mode == 2) begin
                if (out_valid) begin
                    chk("out_data", 32'(out_data), 32'(cap[d_idx]));
                    chk("out_last", 32'(out_last), 32'(d_idx == cap.size() - 1));
                end
            end else begin
                chk("out_valid_idle", 32'(out_valid), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse(input logic with_valid);
        arm = 1'b1; in_valid = with_valid; in_data = 8'h55;
        tick();
        arm = 1'b0; in_valid = 1'b0;
    endtask

    // Sends n beats with in_data = (i mod 256) - 128. in_done can ride on the last beat.
    task automatic beats(input int n, input logic done_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i - 128);
            in_done  = done_last && (i == n - 1);
            tick();
        end
        in_valid = 1'b0; in_done = 1'b0;
    endtask

    task automatic done_pulse();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
    endtask

    // Called just after the edge N that samples in_done. Falling edge k comes
    // after rising edge N+k-1.
    task automatic wait_drain(output int t_first, output int t_last);
        t_first = -1; t_last = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (out_valid && t_first < 0) t_first = k;
            if (out_valid && out_last && out_ready) t_last = k;
            if (!busy) return;
        end
        chk("drain_timeout", 32'd1, 32'd0);
    endtask

    int tf, tl, bad;

    initial begin
        // Reset state
        tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", 32'({overflow, short_frame}), 32'd0);
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        // Nominal full frame with in_done on the last beat
        rx.delete();
        arm_pulse(1'b0);
        beats(DEPTH, 1'b1);
        wait_drain(tf, tl);
        chk("nom_first_latency", 32'(tf), 32'd3);
        chk("nom_last_time", 32'(tl), 32'd198);
        chk("nom_rx_size", 32'(rx.size()), 32'd196);
        chk("nom_rx0", 32'(rx[0]), 32'h80);
        chk("nom_rx195", 32'(rx[195]), 32'h43);
        chk("nom_count", 32'(count), 32'd196);
        chk("nom_flags", 32'({overflow, short_frame}), 32'd0);
        chk("nom_busy", 32'(busy), 32'd0);

        // Backpressure: out_ready toggles every cycle
        rx.delete();
        arm_pulse(1'b0);
        bp_mode = 1'b1;
        beats(DEPTH, 1'b1);
        wait_drain(tf, tl);
        bp_mode = 1'b0;
        tick();
        chk("bp_rx_size", 32'(rx.size()), 32'd196);
        bad = 0;
        for (int i = 0; i < rx.size(); i++) if (rx[i] !== 8'(i - 128)) bad++;
        chk("bp_seq_errors", 32'(bad), 32'd0);
        chk("bp_rx100", 32'(rx[100]), 32'he4);

        // Overflow: 200 beats, then a separate in_done
        rx.delete();
        arm_pulse(1'b0);
        beats(200, 1'b0);
        done_pulse();
        wait_drain(tf, tl);
        chk("ovf_count", 32'(count), 32'd196);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_short", 32'(short_frame), 32'd0);
        chk("ovf_rx_size", 32'(rx.size()), 32'd196);
        chk("ovf_rx195", 32'(rx[195]), 32'h43);

        // Short frame: 100 beats, plus a stray beat while draining
        rx.delete();
        arm_pulse(1'b0);
        beats(100, 1'b1);
        in_valid = 1'b1; in_data = 8'h7f;
        tick();
        in_valid = 1'b0;
        wait_drain(tf, tl);
        chk("short_count", 32'(count), 32'd100);
        chk("short_flag", 32'(short_frame), 32'd1);
        chk("short_drain_ovf", 32'(overflow), 32'd1);
        chk("short_rx_size", 32'(rx.size()), 32'd100);
        chk("short_rx99", 32'(rx[99]), 32'he3);

        // Empty frame: arm, then in_done immediately
        rx.delete();
        arm_pulse(1'b0);
        done_pulse();
        chk("empty_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("empty_count", 32'(count), 32'd0);
        chk("empty_short", 32'(short_frame), 32'd1);
        chk("empty_ovf", 32'(overflow), 32'd0);
        chk("empty_rx_size", 32'(rx.size()), 32'd0);
        tick();

        // Reset after 50 drained beats
        rx.delete();
        arm_pulse(1'b0);
        beats(DEPTH, 1'b1);
        for (int k = 0; k < 400 && rx.size() < 50; k++) tick();
        chk("rst_mid_reached50", 32'(rx.size() >= 50), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        tick();
        rx.delete();
        arm_pulse(1'b0);
        beats(DEPTH, 1'b1);
        wait_drain(tf, tl);
        chk("rearm_rx_size", 32'(rx.size()), 32'd196);
        chk("rearm_rx195", 32'(rx[195]), 32'h43);

        // Re-arm mid-capture after 30 beats; the beat sent with the arm is dropped
        rx.delete();
        arm_pulse(1'b0);
        beats(30, 1'b0);
        arm_pulse(1'b1);
        chk("rearm_mid_count", 32'(count), 32'd0);
        beats(DEPTH, 1'b1);
        wait_drain(tf, tl);
        chk("rearm_mid_rx_size", 32'(rx.size()), 32'd196);
        chk("rearm_mid_rx0", 32'(rx[0]), 32'h80);
        chk("rearm_mid_count_end", 32'(count), 32'd196);
        chk("rearm_mid_flags", 32'({overflow, short_frame}), 32'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer_output_collector.md
# layer_output_collector

Capture buffer for the output stream of a LeNet layer (`data_valid_out` / `pixel_out` / `layer_done` of `lenet_top`), i.e. the receiving end of the layer-output protocol. It is armed per frame and stores up to DEPTH signed pixels in order, with frame-integrity flags. When the layer signals done, it replays the frame to a host over a valid/ready stream. This turns the free-running, no-backpressure layer output into a back-pressurable stream for the next layer or a host DMA.

## Interface
- DATA_W, 8, pixel width (signed)
- DEPTH, 196, words per frame (14x14 pooled map)
- ADDR_W, $clog2(DEPTH), buffer address width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- arm  in  1  one-cycle pulse: clear flags/count, start capture of a new frame
- in_valid  in  1  layer output valid (connects to data_valid_out)
- in_data  in  DATA_W  signed layer pixel (connects to pixel_out)
- in_done  in  1  layer finished (connects to layer_done)
- out_valid  out  1  drain beat valid
- out_data  out  DATA_W  signed drained pixel
- out_last  out  1  high with the final drained beat
- out_ready  in  1  downstream accepts beat
- busy  out  1  high in CAPTURE or DRAIN
- count  out  ADDR_W+1  words captured this frame (0..DEPTH)
- overflow  out  1  sticky: valid beat dropped (buffer full, or arrived in DRAIN)
- short_frame  out  1  sticky: in_done seen with count < DEPTH

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - arm -> CAPTURE; wr_ptr, count, overflow and short_frame cleared.
  - in_valid / in_done ignored, no flag change.
- CAPTURE:
  - in_valid with count < DEPTH: mem[count] <= in_data, count++.
  - in_valid with count == DEPTH: beat dropped, overflow <= 1.
  - arm: restart (same clear as from IDLE); any in_valid in that cycle is dropped.
  - in_done: the in_valid beat of the same cycle is captured first, then evaluated.
    - Final count < DEPTH: short_frame <= 1.
    - Final count == 0: -> IDLE, no drain.
    - Otherwise -> DRAIN with rd_ptr = 0.
- DRAIN:
  - Synchronous-read memory, registered out_data.
  - Beat k presents mem[k]; out_last = (k == count-1).
  - Handshake completes on out_valid && out_ready; rd_ptr advances; the next word is prefetched so back-to-back beats sustain 1 word/cycle.
  - out_valid, out_data and out_last are held stable while out_valid && !out_ready.
  - After the last beat is accepted: -> IDLE; out_valid low the next cycle.
  - in_valid in DRAIN: dropped, overflow <= 1. arm and in_done ignored.
- count, overflow and short_frame hold their values until the next arm or reset.
- Memory contents are never cleared. Data is passed through bit-exact (no arithmetic, no saturation).

## Timing
- Reset (rst == 0 at an edge) state: IDLE; out_valid = 0, out_last = 0, out_data = 0, busy = 0, count = 0, overflow = 0, short_frame = 0. This applies from any state, including mid-CAPTURE and mid-DRAIN.
- busy: rises the cycle after arm is sampled; falls the cycle after the last beat is accepted, or the cycle after in_done when count == 0.
- Drain latency: in_done sampled at edge N -> out_valid high after edge N+2.
- Throughput: 1 beat/cycle with out_ready held high; a full 196-word drain ends with out_last at edge N+197.
- count updates the cycle after each captured beat.

## Test plan
- Nominal frame: arm, then 196 consecutive in_valid beats with in_data = (i mod 256) - 128, in_done coincident with beat 195, out_ready = 1 -> 196 beats in order, identical values, out_last only on beat 195, first out_valid 2 cycles after done, count = 196, both flags 0, busy low afterwards.
- Backpressure: nominal frame with out_ready toggling 1,0,1,0 … -> every stalled beat keeps out_data/out_last stable; the sequence is still 196 correct words with no duplicates or gaps.
- Overflow: 200 in_valid beats then in_done -> count = 196, overflow = 1, short_frame = 0; the drain delivers the first 196 inputs only.
- Short and empty frames:
  - 100 beats then in_done -> short_frame = 1, count = 100; 100 beats drained, out_last on the 100th.
  - arm then immediate in_done -> short_frame = 1, count = 0, IDLE, out_valid never asserts.
- Reset and re-arm:
  - rst low for 1 cycle after 50 drained beats -> next cycle out_valid = 0, busy = 0, count = 0.
  - A new armed 196-beat frame then drains correctly.
  - arm mid-CAPTURE after 30 beats clears count to 0, and the subsequent 196-beat frame drains correctly.
